// File: rtl/apb_bridge_nslave_if.sv
// rtl/apb_bridge_nslave_if.sv - request and APB bus signals of the N-slave bridge
// master is the bridge side; slave is the request source and slave array side.
interface apb_bridge_nslave_if #(
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 2
);
   logic                         transfer;
   logic                         READ_WRITE;
   logic [ADDR_W-1:0]            apb_write_paddr;
   logic [DATA_W-1:0]            apb_write_data;
   logic [ADDR_W-1:0]            apb_read_paddr;
   logic [NUM_SLAVES-1:0]        PSEL;
   logic                         PENABLE;
   logic [ADDR_W-1:0]            PADDR;
   logic                         PWRITE;
   logic [DATA_W-1:0]            PWDATA;
   logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
   logic [NUM_SLAVES-1:0]        PREADY;
   logic [NUM_SLAVES-1:0]        PSLVERR_in;
   logic [DATA_W-1:0]            apb_read_data_out;
   logic                         xfer_done;
   logic                         PSLVERR;

   modport master (
      input  transfer, READ_WRITE, apb_write_paddr, apb_write_data, apb_read_paddr,
      input  PRDATA, PREADY, PSLVERR_in,
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      output apb_read_data_out, xfer_done, PSLVERR
   );

   modport slave (
      output transfer, READ_WRITE, apb_write_paddr, apb_write_data, apb_read_paddr,
      output PRDATA, PREADY, PSLVERR_in,
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      input  apb_read_data_out, xfer_done, PSLVERR
   );
endinterface

// File: rtl/apb_bridge_nslave.sv
// rtl/apb_bridge_nslave.sv - APB master bridge with N-way slave decode, timeout and error reporting
// Completion edges accept the next request directly so back-to-back transfers have no IDLE gap.
module apb_bridge_nslave #(
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 2,
   parameter int TIMEOUT    = 15
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   apb_bridge_nslave_if.master bus
);
   localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] req_addr;
   logic [SEL_W-1:0]  req_idx, sel_idx;
   logic              req_mapped;
   logic [CNT_W-1:0]  wait_cnt;
   logic              ready_sel, slverr_sel;
   logic [DATA_W-1:0] prdata_sel;
   logic              timeout_hit, complete, accept, err_now;
   logic [ADDR_W-1:0] paddr_q;
   logic              pwrite_q;
   logic [DATA_W-1:0] pwdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              done_q, slverr_q;

   function automatic logic is_mapped(input logic [SEL_W-1:0] idx);
      return {1'b0, idx} < (SEL_W + 1)'(NUM_SLAVES);
   endfunction

   always_comb begin
      req_addr   = bus.READ_WRITE ? bus.apb_read_paddr : bus.apb_write_paddr;
      req_idx    = req_addr[ADDR_W-1 -: SEL_W];
      sel_idx    = paddr_q[ADDR_W-1 -: SEL_W];
      req_mapped = is_mapped(req_idx);
   end

   // Only the addressed slave's handshake is observed; others are ignored.
   always_comb begin
      ready_sel  = 1'b0;
      slverr_sel = 1'b0;
      prdata_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_idx == SEL_W'(i)) begin
            ready_sel  = bus.PREADY[i];
            slverr_sel = bus.PSLVERR_in[i];
            prdata_sel = bus.PRDATA[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !ready_sel
                    && (wait_cnt == CNT_W'(TIMEOUT));
      complete    = (state == ERR) || ((state == ACCESS) && (ready_sel || timeout_hit));
      accept      = bus.transfer && ((state == IDLE) || complete);
      err_now     = (state == ERR) || timeout_hit || slverr_sel;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      bus.PSEL    = '0;
      bus.PENABLE = 1'b0;
      case (state)
         IDLE:        if (bus.transfer) state_nxt = req_mapped ? SETUP : ERR;
         SETUP:       state_nxt = ACCESS;
         ACCESS, ERR: if (complete)
                         state_nxt = bus.transfer ? (req_mapped ? SETUP : ERR) : IDLE;
         default:     state_nxt = IDLE;
      endcase
      if (state == SETUP || state == ACCESS) bus.PSEL = NUM_SLAVES'(1) << sel_idx;
      bus.PENABLE = (state == ACCESS);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         wait_cnt <= '0;
         rdata_q  <= '0;
         done_q   <= 1'b0;
         slverr_q <= 1'b0;
      end else begin
         if (accept) begin
            paddr_q  <= req_addr;
            pwrite_q <= ~bus.READ_WRITE;
            if (!bus.READ_WRITE) pwdata_q <= bus.apb_write_data;
         end
         // Saturates at TIMEOUT; with TIMEOUT = 0 it never leaves zero.
         if (state == SETUP)
            wait_cnt <= '0;
         else if (state == ACCESS && !ready_sel && wait_cnt != CNT_W'(TIMEOUT))
            wait_cnt <= wait_cnt + CNT_W'(1);
         done_q <= complete;
         if (complete) begin
            slverr_q <= err_now;
            if (!pwrite_q) rdata_q <= err_now ? '0 : prdata_sel;
         end
      end
   end

   assign bus.PADDR             = paddr_q;
   assign bus.PWRITE            = pwrite_q;
   assign bus.PWDATA            = pwdata_q;
   assign bus.apb_read_data_out = rdata_q;
   assign bus.xfer_done         = done_q;
   assign bus.PSLVERR           = slverr_q;
endmodule

// File: tb/tb_apb_bridge_nslave.sv
// tb/tb_apb_bridge_nslave.sv - directed self-checking bench for apb_bridge_nslave
module tb_apb_bridge_nslave;
   logic PCLK = 1'b0;
   logic PRESETn;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 PCLK = ~PCLK;

   apb_bridge_nslave_if #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(2)) bus_a ();
   apb_bridge_nslave_if #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(3)) bus_b ();

   apb_bridge_nslave #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(2), .TIMEOUT(15)) dut_a (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus_a));
   apb_bridge_nslave #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(3), .TIMEOUT(4)) dut_b (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic cyc();
      @(negedge PCLK);
   endtask

   task automatic req_a(input logic rw, input logic [8:0] addr, input logic [7:0] data);
      bus_a.transfer        = 1'b1;
      bus_a.READ_WRITE      = rw;
      bus_a.apb_read_paddr  = rw ? addr : 9'h1FF;
      bus_a.apb_write_paddr = rw ? 9'h1FF : addr;
      bus_a.apb_write_data  = data;
   endtask

   task automatic req_b(input logic rw, input logic [8:0] addr, input logic [7:0] data);
      bus_b.transfer        = 1'b1;
      bus_b.READ_WRITE      = rw;
      bus_b.apb_read_paddr  = rw ? addr : 9'h1FF;
      bus_b.apb_write_paddr = rw ? 9'h1FF : addr;
      bus_b.apb_write_data  = data;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus_a.transfer = 0; bus_a.READ_WRITE = 0; bus_a.apb_write_paddr = 0;
      bus_a.apb_write_data = 0; bus_a.apb_read_paddr = 0; bus_a.PRDATA = 0;
      bus_a.PREADY = 2'b11; bus_a.PSLVERR_in = 0;
      bus_b.transfer = 0; bus_b.READ_WRITE = 0; bus_b.apb_write_paddr = 0;
      bus_b.apb_write_data = 0; bus_b.apb_read_paddr = 0; bus_b.PRDATA = 0;
      bus_b.PREADY = 3'b111; bus_b.PSLVERR_in = 0;
      PRESETn = 1'b0;
      cyc(); cyc();
      check("rst_psel",    32'(bus_a.PSEL), 0);
      check("rst_penable", 32'(bus_a.PENABLE), 0);
      check("rst_paddr",   32'(bus_a.PADDR), 0);
      check("rst_pwrite",  32'(bus_a.PWRITE), 0);
      check("rst_rdata",   32'(bus_a.apb_read_data_out), 0);
      check("rst_done",    32'(bus_a.xfer_done), 0);
      check("rst_pslverr", 32'(bus_a.PSLVERR), 0);
      PRESETn = 1'b1;
      cyc();

      // zero-wait write to slave 0
      req_a(0, 9'h012, 8'hA5);
      cyc(); bus_a.transfer = 0;
      check("w0_setup_psel",    32'(bus_a.PSEL), 1);
      check("w0_setup_penable", 32'(bus_a.PENABLE), 0);
      check("w0_paddr",         32'(bus_a.PADDR), 32'h012);
      check("w0_pwrite",        32'(bus_a.PWRITE), 1);
      check("w0_pwdata",        32'(bus_a.PWDATA), 32'hA5);
      cyc();
      check("w0_access_psel",    32'(bus_a.PSEL), 1);
      check("w0_access_penable", 32'(bus_a.PENABLE), 1);
      check("w0_access_done",    32'(bus_a.xfer_done), 0);
      cyc();
      check("w0_done",    32'(bus_a.xfer_done), 1);
      check("w0_pslverr", 32'(bus_a.PSLVERR), 0);
      check("w0_idle_psel", 32'(bus_a.PSEL), 0);
      cyc();
      check("w0_done_pulse", 32'(bus_a.xfer_done), 0);

      // read slave 1 with 3 wait states; slave 0 ready/error must be ignored
      bus_a.PRDATA = {8'h3C, 8'h77}; bus_a.PREADY = 2'b01; bus_a.PSLVERR_in = 2'b01;
      req_a(1, 9'h140, 8'h00);
      cyc(); bus_a.transfer = 0;
      check("r1_setup_psel",  32'(bus_a.PSEL), 2);
      check("r1_pwrite",      32'(bus_a.PWRITE), 0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("r1_wait_penable", 32'(bus_a.PENABLE), 1);
         check("r1_wait_done",    32'(bus_a.xfer_done), 0);
      end
      cyc(); bus_a.PREADY = 2'b11;
      check("r1_last_penable", 32'(bus_a.PENABLE), 1);
      cyc();
      check("r1_done",    32'(bus_a.xfer_done), 1);
      check("r1_rdata",   32'(bus_a.apb_read_data_out), 32'h3C);
      check("r1_pslverr", 32'(bus_a.PSLVERR), 0);
      bus_a.PSLVERR_in = 0;

      // back-to-back writes to slaves 0, 1, 0
      req_a(0, 9'h010, 8'h11);
      cyc();
      check("b2b_1_psel", 32'(bus_a.PSEL), 1);
      req_a(0, 9'h120, 8'h22);
      cyc();
      check("b2b_1_paddr_stable",  32'(bus_a.PADDR), 32'h010);
      check("b2b_1_pwdata_stable", 32'(bus_a.PWDATA), 32'h11);
      cyc();
      check("b2b_2_psel",    32'(bus_a.PSEL), 2);
      check("b2b_2_penable", 32'(bus_a.PENABLE), 0);
      check("b2b_2_paddr",   32'(bus_a.PADDR), 32'h120);
      check("b2b_1_done",    32'(bus_a.xfer_done), 1);
      req_a(0, 9'h030, 8'h33);
      cyc();
      check("b2b_2_access_done", 32'(bus_a.xfer_done), 0);
      cyc(); bus_a.transfer = 0;
      check("b2b_3_psel",   32'(bus_a.PSEL), 1);
      check("b2b_3_pwdata", 32'(bus_a.PWDATA), 32'h33);
      check("b2b_2_done",   32'(bus_a.xfer_done), 1);
      cyc();
      check("b2b_3_access_done", 32'(bus_a.xfer_done), 0);
      cyc();
      check("b2b_3_done",  32'(bus_a.xfer_done), 1);
      check("b2b_idle",    32'(bus_a.PSEL), 0);
      check("b2b_rdata_kept", 32'(bus_a.apb_read_data_out), 32'h3C);

      // asynchronous reset during ACCESS
      bus_a.PREADY = 2'b01;
      req_a(0, 9'h150, 8'hC3);
      cyc(); bus_a.transfer = 0;
      cyc();
      check("rst_mid_in_access", 32'(bus_a.PENABLE), 1);
      #1 PRESETn = 1'b0;
      #1;
      check("rst_mid_psel",    32'(bus_a.PSEL), 0);
      check("rst_mid_penable", 32'(bus_a.PENABLE), 0);
      check("rst_mid_paddr",   32'(bus_a.PADDR), 0);
      check("rst_mid_pwdata",  32'(bus_a.PWDATA), 0);
      check("rst_mid_pwrite",  32'(bus_a.PWRITE), 0);
      check("rst_mid_rdata",   32'(bus_a.apb_read_data_out), 0);
      cyc();
      check("rst_mid_no_done", 32'(bus_a.xfer_done), 0);
      PRESETn = 1'b1; bus_a.PREADY = 2'b11; bus_a.PRDATA = {8'h81, 8'h00};
      cyc();
      check("rst_release_no_done", 32'(bus_a.xfer_done), 0);
      req_a(1, 9'h140, 8'h00);
      cyc(); bus_a.transfer = 0;
      cyc(); cyc();
      check("post_rst_done",  32'(bus_a.xfer_done), 1);
      check("post_rst_rdata", 32'(bus_a.apb_read_data_out), 32'h81);

      // slave-reported error on a read clears the read data; PSLVERR holds afterwards
      bus_a.PRDATA = {8'h00, 8'h99}; bus_a.PSLVERR_in = 2'b01;
      req_a(1, 9'h005, 8'h00);
      cyc(); bus_a.transfer = 0;
      cyc(); cyc();
      check("serr_done",    32'(bus_a.xfer_done), 1);
      check("serr_pslverr", 32'(bus_a.PSLVERR), 1);
      check("serr_rdata",   32'(bus_a.apb_read_data_out), 0);
      bus_a.PSLVERR_in = 0;
      cyc();
      check("serr_pulse_end",   32'(bus_a.xfer_done), 0);
      check("serr_pslverr_hold", 32'(bus_a.PSLVERR), 1);

      // three-slave instance: read slave 2
      bus_b.PRDATA = {8'h5A, 8'h00, 8'h00}; bus_b.PREADY = 3'b100;
      req_b(1, 9'h100, 8'h00);
      cyc(); bus_b.transfer = 0;
      check("b_r2_psel", 32'(bus_b.PSEL), 4);
      cyc(); cyc();
      check("b_r2_done",  32'(bus_b.xfer_done), 1);
      check("b_r2_rdata", 32'(bus_b.apb_read_data_out), 32'h5A);

      // TIMEOUT = 4: slave 0 never ready, ACCESS lasts exactly 5 cycles
      bus_b.PREADY = 3'b000;
      req_b(1, 9'h020, 8'h00);
      cyc(); bus_b.transfer = 0;
      check("to_setup_psel", 32'(bus_b.PSEL), 1);
      for (int k = 0; k < 5; k++) begin
         cyc();
         check("to_access_penable", 32'(bus_b.PENABLE), 1);
         check("to_access_done",    32'(bus_b.xfer_done), 0);
      end
      cyc();
      check("to_done",    32'(bus_b.xfer_done), 1);
      check("to_pslverr", 32'(bus_b.PSLVERR), 1);
      check("to_penable", 32'(bus_b.PENABLE), 0);
      check("to_rdata",   32'(bus_b.apb_read_data_out), 0);

      // reload read data, then unmapped address (idx = 3)
      bus_b.PREADY = 3'b100;
      req_b(1, 9'h100, 8'h00);
      cyc(); bus_b.transfer = 0;
      cyc(); cyc();
      check("b_r2b_rdata",   32'(bus_b.apb_read_data_out), 32'h5A);
      check("b_r2b_pslverr", 32'(bus_b.PSLVERR), 0);
      req_b(1, 9'h1C0, 8'h00);
      cyc(); bus_b.transfer = 0;
      check("unm_psel",    32'(bus_b.PSEL), 0);
      check("unm_penable", 32'(bus_b.PENABLE), 0);
      check("unm_c1_done", 32'(bus_b.xfer_done), 0);
      cyc();
      check("unm_done",    32'(bus_b.xfer_done), 1);
      check("unm_pslverr", 32'(bus_b.PSLVERR), 1);
      check("unm_rdata",   32'(bus_b.apb_read_data_out), 0);
      cyc();
      check("unm_pulse_end", 32'(bus_b.xfer_done), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/apb_bridge_nslave.md
# apb_bridge_nslave

Parametrised APB master bridge with an N-way slave decoder, the successor to the fixed two-slave master_bridge. It accepts one read or write request at a time from the local request interface and runs standard SETUP/ACCESS APB phases toward NUM_SLAVES slaves. It also adds three behaviours: back-to-back transfers, a bounded wait-state timeout, and error signalling for unmapped addresses and slave-reported errors. It sits between the test/host request logic and the slave array inside the APB top level.

## Interface
- ADDR_W, 9, PADDR width; the upper SEL_W bits select the slave.
- DATA_W, 8, PWDATA/PRDATA width.
- NUM_SLAVES, 2, number of slaves (≥1); SEL_W = max(1, $clog2(NUM_SLAVES)), derived, not overridable.
- TIMEOUT, 15, maximum PREADY-low ACCESS cycles before forced error; 0 disables the timeout.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- transfer  in  1  request valid; sampled only at IDLE or transfer-completion edges.
- READ_WRITE  in  1  1 = read, 0 = write.
- apb_write_paddr  in  ADDR_W  write address.
- apb_write_data  in  DATA_W  write data.
- apb_read_paddr  in  ADDR_W  read address.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  ACCESS phase indicator.
- PADDR  out  ADDR_W  registered address.
- PWRITE  out  1  registered, equal to ~READ_WRITE at capture.
- PWDATA  out  DATA_W  registered write data.
- PRDATA  in  NUM_SLAVES*DATA_W  flattened slave read data; slave i occupies [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR_in  in  NUM_SLAVES  per-slave error, sampled with PREADY.
- apb_read_data_out  out  DATA_W  read data, registered.
- xfer_done  out  1  one-cycle completion pulse.
- PSLVERR  out  1  error status for the completing transfer; valid while xfer_done = 1.

## Operation
- Decode: idx = captured address bits [ADDR_W-1 -: SEL_W].
  - If idx ≥ NUM_SLAVES, the address is unmapped.
  - With default parameters, idx = PADDR[8].
- Capture, at an edge where the FSM accepts a request:
  - PADDR = READ_WRITE ? apb_read_paddr : apb_write_paddr.
  - PWRITE = ~READ_WRITE.
  - PWDATA = apb_write_data for writes; unchanged for reads.
- FSM states: IDLE, SETUP, ACCESS, ERR.
  - IDLE → SETUP when transfer = 1 and the address is mapped.
  - IDLE → ERR when transfer = 1 and the address is unmapped. No PSEL is asserted.
  - SETUP → ACCESS unconditionally. In SETUP, PSEL[idx] = 1 and PENABLE = 0.
  - In ACCESS, PSEL[idx] = 1 and PENABLE = 1. The transfer completes at the first edge where PREADY[idx] = 1, or where the timeout fires.
  - ERR lasts 1 cycle, then behaves as a completion edge.
- Completion edge:
  - With transfer = 1: capture the new request and go to SETUP (mapped) or ERR (unmapped). There is no IDLE gap.
  - Otherwise, go to IDLE.
- Timeout:
  - wait_cnt is cleared on entry to ACCESS and increments on each ACCESS cycle with PREADY[idx] = 0.
  - When wait_cnt == TIMEOUT and PREADY[idx] is still 0, the transfer is forced complete with an error.
  - The counter never wraps.
- Result, registered one cycle after the completion edge:
  - xfer_done = 1.
  - PSLVERR = (unmapped | timeout | PSLVERR_in[idx]).
  - Read OK: apb_read_data_out = PRDATA slice idx, sampled at the completion edge.
  - Read with error: apb_read_data_out = 0.
  - Writes leave apb_read_data_out unchanged.
- PSLVERR holds its value until the next xfer_done.
- PREADY and PSLVERR_in of non-selected slaves are ignored.

## Timing
- Reset (asynchronous, immediate, including mid-transfer):
  - FSM returns to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, apb_read_data_out, xfer_done, PSLVERR and wait_cnt all go to 0.
  - No completion pulse is generated for an aborted transfer.
- Zero-wait transfer, with transfer sampled at edge 0:
  - SETUP in cycle 1, ACCESS in cycle 2.
  - xfer_done in cycle 3.
- N wait states add N cycles.
- Back-to-back throughput: one transfer per 2 + waits cycles.
- Unmapped address: ERR in cycle 1, xfer_done with PSLVERR = 1 in cycle 2.
- Timeout: the ACCESS phase lasts TIMEOUT + 1 cycles at most.
- PADDR, PWRITE and PWDATA are stable from SETUP until completion.
- Inputs that change while a transfer is in progress have no effect.

## Test plan
- Default parameters, write 8'hA5 to 9'h012, PREADY[0] = 1 → PSEL = 2'b01 in cycle 1 with PENABLE = 0, then PENABLE = 1 in cycle 2, xfer_done in cycle 3 with PSLVERR = 0.
- Read 9'h140, slave 1 holds PREADY low for 3 cycles and returns 8'h3C → ACCESS lasts 4 cycles, PSEL = 2'b10, apb_read_data_out = 8'h3C, PSLVERR = 0.
- NUM_SLAVES = 3, read address 9'h1C0 (idx = 3) → no PSEL asserted, xfer_done with PSLVERR = 1 two cycles after request, apb_read_data_out = 0.
- TIMEOUT = 4, slave 0 never ready → ACCESS lasts exactly 5 cycles, then xfer_done with PSLVERR = 1.
- transfer held high for 3 writes to slaves 0, 1, 0 with zero waits → SETUP follows ACCESS directly, 3 xfer_done pulses 2 cycles apart.
- Assert PRESETn = 0 during ACCESS → all outputs go to 0 immediately, no xfer_done; the next request after reset release completes normally.
